// File: rtl/ps2_scancode_receiver.sv
`timescale 1ns/1ps
// ps2_scancode_receiver
//
// Receives PS/2 keyboard frames from the raw pins and checks each frame.
// Valid scancodes go into a small FIFO, which is read by the MiniAlu TEC
// instruction. Framing and parity problems raise sticky flags.
//
// Parameters:
//   SAMPLE_DIV     - Clock cycles between glitch-filter samples
//   FILTER_LEN     - equal consecutive samples needed to change a filtered level
//   TIMEOUT_CYCLES - cycles without a PS/2 falling edge that abort a frame
//   FIFO_DEPTH     - scancode entries (power of 2, >= 2)
//
// Ports:
//   Clock, Reset      - system clock; asynchronous active-high reset
//   iPs2Clk, iPs2Data - raw asynchronous PS/2 pins
//   iPop              - pop the FIFO head (one entry per cycle held high)
//   iClearFlags       - clear all sticky error flags
//   oKey              - FIFO head scancode, 0 when empty
//   oValid            - FIFO not empty
//   oFrameError       - sticky: bad start/stop bit or timeout
//   oParityError      - sticky: odd-parity check failed
//   oOverflow         - sticky: valid byte dropped on a full FIFO
//
// Optional feature macro: PS2_BREAK_FILTER_EN
//   When defined, 0xF0 and the byte that follows it are not queued, so
//   only make codes reach the FIFO.

module ps2_scancode_receiver #(
  parameter int SAMPLE_DIV     = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iPs2Clk,
  input  logic       iPs2Data,
  input  logic       iPop,
  input  logic       iClearFlags,
  output logic [7:0] oKey,
  output logic       oValid,
  output logic       oFrameError,
  output logic       oParityError,
  output logic       oOverflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int SDW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} fsmState_t;

  // Stage p0/p1: two-flop synchronizers for the asynchronous pins
  logic clkSync_p0, clkSync_p1, dataSync_p0, dataSync_p1;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clkSync_p0  <= 1'b1;
      clkSync_p1  <= 1'b1;
      dataSync_p0 <= 1'b1;
      dataSync_p1 <= 1'b1;
    end else begin
      clkSync_p0  <= iPs2Clk;
      clkSync_p1  <= clkSync_p0;
      dataSync_p0 <= iPs2Data;
      dataSync_p1 <= dataSync_p0;
    end
  end

  // Glitch filter: sample every SAMPLE_DIV cycles, change level only
  // when the whole history agrees
  logic [SDW-1:0]        sampleCnt;
  logic                  sampleTick;
  logic [FILTER_LEN-1:0] clkHist, dataHist;
  logic                  filtClk, filtData, filtClkDly;
  logic                  psEdge;

  assign sampleTick = (sampleCnt == SDW'(SAMPLE_DIV - 1));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sampleCnt  <= '0;
      clkHist    <= '1;
      dataHist   <= '1;
      filtClk    <= 1'b1;
      filtData   <= 1'b1;
      filtClkDly <= 1'b1;
    end else begin
      sampleCnt <= sampleTick ? '0 : sampleCnt + SDW'(1);
      if (sampleTick) begin
        clkHist  <= {clkHist[FILTER_LEN-2:0], clkSync_p1};
        dataHist <= {dataHist[FILTER_LEN-2:0], dataSync_p1};
      end
      if (&clkHist)   filtClk  <= 1'b1;
      if (~|clkHist)  filtClk  <= 1'b0;
      if (&dataHist)  filtData <= 1'b1;
      if (~|dataHist) filtData <= 1'b0;
      filtClkDly <= filtClk;
    end
  end

  assign psEdge = filtClkDly & ~filtClk;

  // Frame FSM with watchdog
  fsmState_t      state, stateNext;
  logic [7:0]     shiftReg, shiftNext;
  logic [2:0]     bitCnt, bitCntNext;
  logic           parityBit, parityNext;
  logic [WDW-1:0] wdCnt;
  logic           timeout, validByte, pushReq;
  logic           frameErrSet, parityErrSet, ovfSet;

  assign timeout = (state != IDLE) && (wdCnt >= WDW'(TIMEOUT_CYCLES));

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      bitCnt <= '0;
      wdCnt  <= '0;
    end else begin
      state  <= stateNext;
      bitCnt <= bitCntNext;
      if (psEdge || state == IDLE) wdCnt <= '0;
      else if (!timeout)           wdCnt <= wdCnt + WDW'(1);
    end
  end

  always_ff @(posedge Clock) begin
    shiftReg  <= shiftNext;
    parityBit <= parityNext;
  end

  always_comb begin
    stateNext    = state;
    shiftNext    = shiftReg;
    bitCntNext   = bitCnt;
    parityNext   = parityBit;
    validByte    = 1'b0;
    frameErrSet  = 1'b0;
    parityErrSet = 1'b0;
    case (state)
      IDLE: if (psEdge) begin
        if (!filtData) begin
          stateNext  = DATA;
          bitCntNext = '0;
        end else begin
          frameErrSet = 1'b1;
        end
      end
      DATA: if (psEdge) begin
        shiftNext  = {filtData, shiftReg[7:1]};
        bitCntNext = bitCnt + 3'd1;
        if (bitCnt == 3'd7) stateNext = PARITY;
      end
      PARITY: if (psEdge) begin
        parityNext = filtData;
        stateNext  = STOP;
      end
      STOP: if (psEdge) begin
        stateNext = IDLE;
        if (!filtData)                   frameErrSet  = 1'b1;
        else if (^{shiftReg, parityBit}) validByte    = 1'b1;
        else                             parityErrSet = 1'b1;
      end
      default: stateNext = IDLE;
    endcase
    if (timeout) begin
      stateNext   = IDLE;
      frameErrSet = 1'b1;
      validByte   = 1'b0;
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  // One-shot: 0xF0 arms it, the following valid byte is swallowed
  logic breakArmed;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)            breakArmed <= 1'b0;
    else if (frameErrSet) breakArmed <= 1'b0;
    else if (validByte)   breakArmed <= breakArmed ? 1'b0 : (shiftReg == 8'hF0);
  end

  assign pushReq = validByte & ~breakArmed & (shiftReg != 8'hF0);
`else
  assign pushReq = validByte;
`endif

  // Scancode FIFO; pointers carry an extra wrap bit for full/empty
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic        empty, full, doPop, doPush;

  assign empty  = (wrPtr == rdPtr);
  assign full   = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign doPop  = iPop & ~empty;
  // A pop in the same cycle frees the slot for a push into a full FIFO
  assign doPush = pushReq & (~full | doPop);
  assign ovfSet = pushReq & full & ~doPop;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + (AW+1)'(1);
      if (doPop)  rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= shiftReg;
  end

  assign oValid = ~empty;
  assign oKey   = empty ? 8'h00 : mem[rdPtr[AW-1:0]];

  // Sticky flags: a set in the same cycle as a clear wins
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oFrameError  <= 1'b0;
      oParityError <= 1'b0;
      oOverflow    <= 1'b0;
    end else begin
      oFrameError  <= frameErrSet  | (oFrameError  & ~iClearFlags);
      oParityError <= parityErrSet | (oParityError & ~iClearFlags);
      oOverflow    <= ovfSet       | (oOverflow    & ~iClearFlags);
    end
  end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
`timescale 1ns/1ps
module tb_ps2_scancode_receiver;

  localparam int H = 40;  // PS/2 half period in Clock cycles

  logic       Clock = 1'b0;
  logic       Reset, iPs2Clk, iPs2Data, iPop, iClearFlags;
  logic [7:0] oKey;
  logic       oValid, oFrameError, oParityError, oOverflow;

  int         nVec  = 0;
  int         nFail = 0;
  logic [7:0] expQ[$];
  logic [7:0] dummy;
  bit         expOvf = 1'b0;
  bit         armed  = 1'b0;
  int         lat, lat0;

  ps2_scancode_receiver dut (
    .Clock(Clock), .Reset(Reset), .iPs2Clk(iPs2Clk), .iPs2Data(iPs2Data),
    .iPop(iPop), .iClearFlags(iClearFlags), .oKey(oKey), .oValid(oValid),
    .oFrameError(oFrameError), .oParityError(oParityError), .oOverflow(oOverflow)
  );

  always #10 Clock = ~Clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, observed running, expected finished");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  function automatic logic [10:0] frameBits(input logic [7:0] b, input bit parFlip, input bit stopVal);
    return {stopVal, (~^b) ^ parFlip, b, 1'b0};
  endfunction

  // Reference behaviour for a correctly received byte
  task automatic modelByte(input logic [7:0] b);
    bit accept;
    accept = 1'b1;
`ifdef PS2_BREAK_FILTER_EN
    if (armed) begin
      armed = 1'b0;
      accept = 1'b0;
    end else if (b == 8'hF0) begin
      armed = 1'b1;
      accept = 1'b0;
    end
`endif
    if (accept) begin
      if (expQ.size() < 4) expQ.push_back(b);
      else expOvf = 1'b1;
    end
  endtask

  // Drives nBits of a frame. On the stop bit it can record when oValid
  // rises and assert iPop so that it is sampled on cycle popAt.
  task automatic sendRaw(input logic [10:0] bits, input int nBits, input int popAt,
                         input bit measure, output int latOut);
    latOut = 0;
    for (int k = 0; k < nBits; k++) begin
      iPs2Data = bits[k];
      iPs2Clk  = 1'b1;
      tick(H);
      iPs2Clk  = 1'b0;
      for (int i = 1; i <= H; i++) begin
        @(posedge Clock);
        #1;
        if (k == 10) begin
          if (measure && latOut == 0 && oValid) latOut = i;
          if (popAt > 1 && i == popAt - 1 && expQ.size() > 0) begin
            check("head_before_coincident_pop", oKey, expQ[0]);
            dummy = expQ.pop_front();
            iPop = 1'b1;
          end else begin
            iPop = 1'b0;
          end
        end
      end
      iPs2Clk = 1'b1;
    end
    iPs2Data = 1'b1;
    tick(H);
  endtask

  task automatic sendByte(input logic [7:0] b);
    int l;
    sendRaw(frameBits(b, 1'b0, 1'b1), 11, 0, 1'b0, l);
    modelByte(b);
  endtask

  task automatic popCheck(input string tag);
    logic [7:0] e;
    e = (expQ.size() != 0) ? expQ.pop_front() : 8'h00;
    check(tag, oKey, e);
    iPop = 1'b1;
    tick(1);
    iPop = 1'b0;
    tick(1);
  endtask

  task automatic clearFlags();
    iClearFlags = 1'b1;
    tick(1);
    iClearFlags = 1'b0;
    tick(1);
  endtask

  task automatic checkFlags(input string tag, input bit f, input bit p, input bit o);
    check({tag, "_frameErr"}, oFrameError, f);
    check({tag, "_parityErr"}, oParityError, p);
    check({tag, "_overflow"}, oOverflow, o);
  endtask

  initial begin
    Reset = 1'b1; iPs2Clk = 1'b1; iPs2Data = 1'b1; iPop = 1'b0; iClearFlags = 1'b0;
    @(posedge Clock);
    #1;
    tick(3);
    check("reset_oKey", oKey, 8'h00);
    check("reset_oValid", oValid, 1'b0);
    checkFlags("reset", 1'b0, 1'b0, 1'b0);
    Reset = 1'b0;
    tick(4);

    // Single frame
    sendByte(8'h1C);
    check("single_valid", oValid, 1'b1);
    checkFlags("single", 1'b0, 1'b0, 1'b0);
    popCheck("single_key");
    check("single_empty_valid", oValid, 1'b0);
    check("single_empty_key", oKey, 8'h00);

    // Parity error
    sendRaw(frameBits(8'h1C, 1'b1, 1'b1), 11, 0, 1'b0, lat);
    check("parity_fifo_empty", oValid, 1'b0);
    checkFlags("parity", 1'b0, 1'b1, 1'b0);
    clearFlags();
    check("parity_cleared", oParityError, 1'b0);

    // Bad stop bit
    sendRaw(frameBits(8'h1C, 1'b0, 1'b0), 11, 0, 1'b0, lat);
    check("stop_fifo_empty", oValid, 1'b0);
    checkFlags("badstop", 1'b1, 1'b0, 1'b0);
    clearFlags();
    check("badstop_cleared", oFrameError, 1'b0);

    // Pop while empty leaves the pointers alone
    iPop = 1'b1;
    tick(1);
    iPop = 1'b0;
    tick(1);
    check("pop_empty_valid", oValid, 1'b0);
    check("pop_empty_key", oKey, 8'h00);

    // Glitch rejection
    iPs2Clk = 1'b0;
    tick(5);
    iPs2Clk = 1'b1;
    tick(95);
    check("glitch_no_frame_err", oFrameError, 1'b0);
    check("glitch_valid", oValid, 1'b0);

    // Timeout after 4 data bits
    sendRaw(frameBits(8'h32, 1'b0, 1'b1), 5, 0, 1'b0, lat);
    tick(200);
    check("timeout_not_yet", oFrameError, 1'b0);
    tick(50000);
    check("timeout_frame_err", oFrameError, 1'b1);
    check("timeout_valid", oValid, 1'b0);
    clearFlags();
    sendByte(8'h32);
    checkFlags("after_timeout", 1'b0, 1'b0, 1'b0);
    popCheck("after_timeout_key");

    // Overflow: five bytes, no pops
    sendRaw(frameBits(8'h01, 1'b0, 1'b1), 11, 0, 1'b1, lat0);
    modelByte(8'h01);
    check("push_latency_window", (lat0 >= 2 && lat0 <= H), 1'b1);
    if (lat0 < 2) lat0 = 20;
    for (int b = 2; b <= 5; b++) sendByte(8'(b));
    check("overflow_flag", oOverflow, expOvf);
    for (int b = 1; b <= 4; b++) popCheck("overflow_pop");
    check("overflow_drained", oValid, 1'b0);
    clearFlags();
    check("overflow_cleared", oOverflow, 1'b0);
    expOvf = 1'b0;

    // Full FIFO with a pop coincident with the 5th push
    for (int b = 1; b <= 4; b++) sendByte(8'(b));
    sendRaw(frameBits(8'h05, 1'b0, 1'b1), 11, lat0, 1'b0, lat);
    modelByte(8'h05);
    check("coincident_no_overflow", oOverflow, expOvf);
    for (int b = 0; b < 4; b++) popCheck("coincident_pop");
    check("coincident_drained", oValid, 1'b0);

    // Break code sequence
    sendByte(8'h1C);
    sendByte(8'hF0);
    sendByte(8'h1C);
    checkFlags("break", 1'b0, 1'b0, 1'b0);
    while (expQ.size() > 0) popCheck("break_pop");
    check("break_drained", oValid, 1'b0);

    // Reset mid-frame with two entries queued and a flag set
    sendRaw(frameBits(8'h44, 1'b1, 1'b1), 11, 0, 1'b0, lat);
    sendByte(8'h11);
    sendByte(8'h22);
    check("pre_reset_valid", oValid, 1'b1);
    check("pre_reset_parity", oParityError, 1'b1);
    sendRaw(frameBits(8'h2B, 1'b0, 1'b1), 4, 0, 1'b0, lat);
    Reset = 1'b1;
    #1;
    check("midreset_oKey", oKey, 8'h00);
    check("midreset_oValid", oValid, 1'b0);
    checkFlags("midreset", 1'b0, 1'b0, 1'b0);
    expQ.delete();
    armed = 1'b0;
    tick(2);
    Reset = 1'b0;
    tick(4);
    sendByte(8'h2B);
    check("post_reset_valid", oValid, 1'b1);
    popCheck("post_reset_key");
    checkFlags("post_reset", 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
